// File: rtl/mem_stage.sv
// mem_stage: RISC-V memory stage with a 3-state data-memory handshake FSM.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    f3_q, f3_d;
    logic [4:0]    rd_q, rd_d;
    logic          store_q, store_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          err_q, err_d;

    logic [31:0] addr_al;
    logic [31:0] wdata_new;
    logic [3:0]  be_new;
    logic        f3_ok;
    logic        misalign;
    logic        trap;
    logic        timeout;
    logic        in_req;

    function automatic logic [31:0] load_ext(
        input logic [31:0] rdata,
        input logic [2:0]  f3,
        input logic [1:0]  lane
    );
        logic [31:0] sh;
        sh = rdata >> {lane, 3'b000};
        unique case (f3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_ext = {24'h0, sh[7:0]};
            3'b101:  load_ext = {16'h0, sh[15:0]};
            default: load_ext = rdata;
        endcase
    endfunction

    // Decode the incoming op: legal funct3, aligned address, lanes and data.
    always_comb begin
        addr_al   = addr_i;
        be_new    = 4'b1111;
        wdata_new = store_data_i;
        if (is_store_i) begin
            f3_ok = funct3_i inside {3'b000, 3'b001, 3'b010};
        end else begin
            f3_ok = funct3_i inside {3'b000, 3'b001, 3'b010,
                                     3'b100, 3'b101};
        end
        unique case (funct3_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                addr_al   = {addr_i[31:1], 1'b0};
                be_new    = 4'b0011 << addr_al[1:0];
                wdata_new = {2{store_data_i[15:0]}};
            end
            default: begin
                addr_al = {addr_i[31:2], 2'b00};
            end
        endcase
        misalign = (addr_al != addr_i);
`ifdef MEM_MISALIGN_TRAP_EN
        trap = misalign;
`else
        trap = 1'b0;
`endif
    end

    assign in_req  = (state_q == REQ);
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Next-state, capture and writeback result logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        store_d    = store_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = 32'd0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!is_load_i && !is_store_i) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_i;
                        wb_data_d  = addr_i;
                    end else if (!f3_ok || trap) begin
                        wb_valid_d = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        addr_d  = addr_al;
                        wdata_d = wdata_new;
                        be_d    = be_new;
                        f3_d    = funct3_i;
                        rd_d    = rd_i;
                        store_d = is_store_i;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i && store_q) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                end else if (dmem_gnt_i && dmem_rvalid_i) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_ext(dmem_rdata_i, f3_q, addr_q[1:0]);
                end else if (timeout) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (dmem_gnt_i) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_ext(dmem_rdata_i, f3_q, addr_q[1:0]);
                end else if (timeout) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured op and registered writeback result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            f3_q       <= 3'd0;
            rd_q       <= 5'd0;
            store_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            store_q    <= store_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign dmem_req_o   = in_req;
    assign dmem_we_o    = in_req & store_q;
    assign dmem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_wdata_o = in_req ? wdata_q : 32'd0;
    assign dmem_be_o    = in_req ? be_q : 4'd0;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage, TIMEOUT_CYCLES=4.
// Honors MEM_MISALIGN_TRAP_EN for the misaligned halfword case.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        ready_o;
    logic        is_load_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    int n_chk  = 0;
    int n_pass = 0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .is_load_i    (is_load_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .rd_i         (rd_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd);
        valid_i      = 1'b1;
        is_load_i    = ld;
        is_store_i   = st;
        funct3_i     = f3;
        addr_i       = a;
        store_data_i = d;
        rd_i         = rd;
        cyc();
        valid_i    = 1'b0;
        is_load_i  = 1'b0;
        is_store_i = 1'b0;
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input bit same);
        issue(1'b1, 1'b0, f3, a, 32'd0, rd);
        dmem_gnt_i = 1'b1;
        if (same) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rdata;
        end
        cyc();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        if (!same) begin
            dmem_rdata_i  = rdata;
            dmem_rvalid_i = 1'b1;
            cyc();
            dmem_rvalid_i = 1'b0;
        end
    endtask

    initial begin
        reset         = 1'b1;
        valid_i       = 1'b0;
        is_load_i     = 1'b0;
        is_store_i    = 1'b0;
        funct3_i      = 3'd0;
        addr_i        = 32'd0;
        store_data_i  = 32'd0;
        rd_i          = 5'd0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        cyc();
        cyc();
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_wbv", 32'(wb_valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        reset = 1'b0;
        cyc();
        check("post_rst_ready", 32'(ready_o), 32'd1);

        // non-memory pass-through
        issue(1'b0, 1'b0, 3'd0, 32'h1234, 32'd0, 5'd5);
        check("alu_wbv", 32'(wb_valid_o), 32'd1);
        check("alu_data", wb_data_o, 32'h1234);
        check("alu_rd", 32'(wb_rd_o), 32'd5);
        check("alu_ready", 32'(ready_o), 32'd1);
        cyc();
        check("alu_pulse", 32'(wb_valid_o), 32'd0);

        // SB 0x103, grant in the third request cycle
        issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB, 5'd0);
        for (int i = 0; i < 3; i++) begin
            check("sb_req", 32'(dmem_req_o), 32'd1);
            check("sb_we", 32'(dmem_we_o), 32'd1);
            check("sb_addr", dmem_addr_o, 32'h100);
            check("sb_be", 32'(dmem_be_o), 32'b1000);
            check("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
            check("sb_nowb", 32'(wb_valid_o), 32'd0);
            if (i == 2) dmem_gnt_i = 1'b1;
            cyc();
        end
        dmem_gnt_i = 1'b0;
        check("sb_wbv", 32'(wb_valid_o), 32'd1);
        check("sb_rd", 32'(wb_rd_o), 32'd0);
        check("sb_err", 32'(err_o), 32'd0);
        check("sb_req_off", 32'(dmem_req_o), 32'd0);
        cyc();
        check("sb_pulse", 32'(wb_valid_o), 32'd0);

        // SH / SW lanes
        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_CDEF, 5'd0);
        check("sh_be", 32'(dmem_be_o), 32'b1100);
        check("sh_wdata", dmem_wdata_o, 32'hCDEF_CDEF);
        dmem_gnt_i = 1'b1;
        cyc();
        dmem_gnt_i = 1'b0;
        check("sh_wbv", 32'(wb_valid_o), 32'd1);
        issue(1'b0, 1'b1, 3'b010, 32'h104, 32'h1234_CDEF, 5'd0);
        check("sw_be", 32'(dmem_be_o), 32'b1111);
        check("sw_wdata", dmem_wdata_o, 32'h1234_CDEF);
        check("sw_addr", dmem_addr_o, 32'h104);
        dmem_gnt_i = 1'b1;
        cyc();
        dmem_gnt_i = 1'b0;
        check("sw_wbv", 32'(wb_valid_o), 32'd1);

        // LB / LBU 0x102
        load_op(3'b000, 32'h102, 5'd7, 32'h0080_0000, 1'b0);
        check("lb_wbv", 32'(wb_valid_o), 32'd1);
        check("lb_data", wb_data_o, 32'hFFFF_FF80);
        check("lb_rd", 32'(wb_rd_o), 32'd7);
        check("lb_err", 32'(err_o), 32'd0);
        load_op(3'b100, 32'h102, 5'd8, 32'h0080_0000, 1'b0);
        check("lbu_data", wb_data_o, 32'h0000_0080);

        // LH / LHU upper half
        load_op(3'b001, 32'h202, 5'd9, 32'h89AB_0000, 1'b0);
        check("lh_data", wb_data_o, 32'hFFFF_89AB);
        load_op(3'b101, 32'h202, 5'd9, 32'h89AB_0000, 1'b0);
        check("lhu_data", wb_data_o, 32'h0000_89AB);

        // LW with gnt and rvalid together
        load_op(3'b010, 32'h200, 5'd3, 32'hDEAD_BEEF, 1'b1);
        check("lw_wbv", 32'(wb_valid_o), 32'd1);
        check("lw_data", wb_data_o, 32'hDEAD_BEEF);
        check("lw_ready", 32'(ready_o), 32'd1);
        cyc();
        check("lw_pulse", 32'(wb_valid_o), 32'd0);

        // stray rvalid in IDLE and in REQ
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5555_5555;
        cyc();
        check("rv_idle", 32'(wb_valid_o), 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd4);
        dmem_rvalid_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        cyc();
        dmem_rvalid_i = 1'b0;
        check("rv_req_nowb", 32'(wb_valid_o), 32'd0);
        check("rv_req_held", 32'(dmem_req_o), 32'd1);
        load_op(3'b010, 32'h300, 5'd4, 32'h0BAD_F00D, 1'b0);

        // unsupported funct3
        issue(1'b1, 1'b0, 3'b011, 32'h400, 32'd0, 5'd6);
        check("bad_ld_wbv", 32'(wb_valid_o), 32'd1);
        check("bad_ld_err", 32'(err_o), 32'd1);
        check("bad_ld_data", wb_data_o, 32'd0);
        check("bad_ld_noreq", 32'(dmem_req_o), 32'd0);
        issue(1'b0, 1'b1, 3'b100, 32'h400, 32'hFFFF_FFFF, 5'd0);
        check("bad_st_err", 32'(err_o), 32'd1);
        check("bad_st_noreq", 32'(dmem_req_o), 32'd0);
        cyc();
        check("bad_pulse", 32'(err_o), 32'd0);

        // timeout in REQ
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 5'd2);
        for (int i = 0; i < 4; i++) begin
            check("to_req", 32'(dmem_req_o), 32'd1);
            cyc();
        end
        check("to_req_drop", 32'(dmem_req_o), 32'd0);
        check("to_wbv", 32'(wb_valid_o), 32'd1);
        check("to_err", 32'(err_o), 32'd1);
        check("to_data", wb_data_o, 32'd0);

        // timeout in WAIT, counted from request start
        issue(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 5'd2);
        dmem_gnt_i = 1'b1;
        cyc();
        dmem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("tow_nowb", 32'(wb_valid_o), 32'd0);
            cyc();
        end
        check("tow_err", 32'(err_o), 32'd1);
        check("tow_wbv", 32'(wb_valid_o), 32'd1);

        // misaligned LH 0x101
        issue(1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 5'd1);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_noreq", 32'(dmem_req_o), 32'd0);
        check("mis_err", 32'(err_o), 32'd1);
        check("mis_wbv", 32'(wb_valid_o), 32'd1);
`else
        check("mis_req", 32'(dmem_req_o), 32'd1);
        check("mis_addr", dmem_addr_o, 32'h100);
        check("mis_be", 32'(dmem_be_o), 32'b0011);
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h0000_8001;
        cyc();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        check("mis_data", wb_data_o, 32'hFFFF_8001);
        check("mis_err", 32'(err_o), 32'd0);
`endif

        // reset during REQ
        cyc();
        issue(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 5'd2);
        check("rmid_req", 32'(dmem_req_o), 32'd1);
        reset = 1'b1;
        #1;
        check("rmid_drop", 32'(dmem_req_o), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        check("rmid_nowb", 32'(wb_valid_o), 32'd0);
        check("rmid_ready", 32'(ready_o), 32'd1);
        cyc();
        check("rmid_nowb2", 32'(wb_valid_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles a memory access may remain in REQ plus WAIT before it is aborted.
REQ-002 clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid_i  input  1  execute-stage op is present this cycle.
REQ-005 ready_o  output  1  block accepts an op; an op transfers when valid_i and ready_o are both 1.
REQ-006 is_load_i / is_store_i  input  1 each  op type; both 0 = non-memory op.
REQ-007 funct3_i  input  3  access size and signedness.
REQ-008 addr_i  input  32  ALU result: memory address, or pass-through result for non-memory ops.
REQ-009 store_data_i  input  32  rs2 value.
REQ-010 rd_i  input  5  destination register.
REQ-011 dmem_req_o / dmem_we_o  output  1 each  memory request and write enable.
REQ-012 dmem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 dmem_wdata_o  output  32; dmem_be_o  output  4  byte enables.
REQ-014 dmem_gnt_i / dmem_rvalid_i  input  1 each  request accepted / read data valid; dmem_rdata_i  input  32.
REQ-015 wb_valid_o  output  1; wb_rd_o  output  5; wb_data_o  output  32; err_o  output  1  result to writeback.

Function
REQ-016 The FSM SHALL use three states: IDLE, REQ, WAIT; ready_o SHALL be 1 only in IDLE.
REQ-017 A non-memory op accepted in cycle N SHALL produce wb_valid_o=1, wb_data_o=addr_i, wb_rd_o=rd_i in cycle N+1, with the FSM remaining in IDLE.
REQ-018 A load or store accepted SHALL move IDLE->REQ and latch addr, data, funct3, rd and type.
REQ-019 In REQ, dmem_req_o=1 and dmem_addr_o/wdata_o/be_o/we_o SHALL stay stable until dmem_gnt_i=1.
REQ-020 Store on gnt: REQ->IDLE; wb_valid_o=1 next cycle, wb_rd_o=0.
REQ-021 Load on gnt: REQ->WAIT; if dmem_rvalid_i is 1 in the same cycle as gnt, the FSM SHALL complete directly to IDLE.
REQ-022 On rvalid in WAIT: WAIT->IDLE; wb_valid_o=1 next cycle carrying the extended load data.
REQ-023 wb_valid_o SHALL be a one-cycle pulse per op; exactly one result per accepted op.
REQ-024 Store lanes: SB (000) be=0001<<addr[1:0], wdata = byte replicated x4; SH (001) be=0011<<addr[1:0], wdata = half replicated x2; SW (010) be=1111.
REQ-025 Loads: LB 000 and LH 001 sign-extend, LW 010 full word, LBU 100 and LHU 101 zero-extend; the lane is selected by addr[1:0].
REQ-026 An unsupported funct3 on a load or store SHALL issue no request and produce wb_valid_o=1, err_o=1, wb_data_o=0 next cycle.
REQ-027 A cycle counter SHALL count in REQ plus WAIT; on reaching TIMEOUT_CYCLES the block SHALL drop dmem_req_o, go to IDLE, and pulse wb_valid_o with err_o=1, wb_data_o=0.
REQ-028 dmem_rvalid_i outside WAIT (and not same-cycle with gnt) SHALL be ignored.

Reset
REQ-029 While reset=1: FSM=IDLE, counter=0, every output 0 except ready_o.
REQ-030 ready_o SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset during REQ or WAIT SHALL drop dmem_req_o asynchronously, with no wb_valid_o for the aborted op.

Configuration
REQ-032 Macro MEM_MISALIGN_TRAP_EN defined: a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 issues no request and returns err_o=1 next cycle.
REQ-033 Macro undefined: misaligned addresses are aligned down (low bits cleared to the access size) and the access proceeds normally with err_o=0.

Verification
REQ-034 Non-memory op, addr_i=0x1234, rd=5 -> next cycle wb_valid_o=1, wb_data_o=0x1234, wb_rd_o=5.
REQ-035 SB addr=0x103, data=0xAB -> dmem_addr_o=0x100, be=1000, wdata=0xABABABAB; gnt after 3 cycles -> single wb pulse with req held stable throughout.
REQ-036 LB addr=0x102, rdata=0x00800000 -> wb_data_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-037 LW with gnt and rvalid in the same cycle, rdata=0xDEADBEEF -> wb_data_o=0xDEADBEEF one cycle later, FSM back in IDLE.
REQ-038 Load never granted, TIMEOUT_CYCLES=4 -> req drops after 4 cycles, wb_valid_o=1, err_o=1.
REQ-039 LH addr=0x101 with the macro defined -> no dmem_req_o, err_o=1; without the macro -> dmem_addr_o=0x100, be=0011.
